chan_scan_serializer: RTL and testbench
=======================================

Name: chan_scan_serializer

Overview:
- Parametrised successor to the spectrogram bin select mux.
- Snapshots N_CH parallel frequency-bin magnitudes on a start request, then streams them out one channel per handshake, tagged with the channel index.
- Sits between the filter-bank magnitude registers and the narrow output/readout path.
- Adds framing, backpressure, continuous mode and a missed-start flag, which the plain mux lacks.

Parameters:
- N_CH, 16, number of input channels; must be ≥2.
- DATA_W, 12, bits per channel.
- IDX_W, $clog2(N_CH), width of the channel index.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  N_CH*DATA_W  flattened channels; channel k occupies bits [k*DATA_W +: DATA_W].
- start  input  1  frame request; level-sampled.
- cont  input  1  continuous mode; sampled at the last beat of each frame.
- out_ready  input  1  downstream ready.
- out_valid  output  1  data_out/ch_idx hold a valid beat.
- data_out  output  DATA_W  snapshot value of channel ch_idx.
- ch_idx  output  IDX_W  index of the current beat.
- busy  output  1  high in SEND.
- frame_done  output  1  one-cycle pulse after the last beat is accepted.
- start_missed  output  1  sticky; start was seen while busy.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; out_valid=0, data_out=0, ch_idx=0, busy=0, frame_done=0, start_missed=0; snapshot register cleared to 0.
- Snapshot register: N_CH*DATA_W flops. Loaded only on capture. data_in changes during SEND never affect the output.
- IDLE:
  - If start=1 at an edge: capture data_in, set idx=0, go to SEND.
  - At that same edge: out_valid←1, data_out←data_in ch0, ch_idx←0, busy←1.
  - Latency: start at edge T gives the first beat visible after T, i.e. one cycle.
- SEND:
  - A beat transfers on an edge with out_valid & out_ready.
  - No transfer: data_out, ch_idx and out_valid hold stable (AXI-style). out_valid never drops without a transfer.
  - Transfer with idx<N_CH-1: idx++, and data_out/ch_idx update at that edge. Back-to-back beats are allowed, so throughput is one beat per cycle when ready stays high.
  - Transfer with idx=N_CH-1 and cont=0: go to IDLE; out_valid←0, busy←0, frame_done←1 for one cycle.
  - Transfer with idx=N_CH-1 and cont=1: frame_done←1, re-capture data_in at the same edge, idx←0, stay in SEND. Beat 0 of the new frame follows with no gap.
- start while in SEND, excluding the last-beat transfer edge with cont=1:
  - Ignored for framing.
  - Sets start_missed←1.
- start_missed is cleared only at an IDLE→SEND capture edge (the new value is 0) and by reset.
- start=1 at the final-beat edge with cont=0 does not re-capture. The block returns to IDLE, and start is honoured the next cycle if still high.
- Reset mid-frame: immediate return to reset values. No frame_done pulse; the partial frame is discarded.
- ch_idx is zero-extended. Index values ≥N_CH are never produced (non-power-of-2 N_CH is supported).
- Outputs are all registered; there is no combinational path from input to output.

Test Plan:
- Single frame, N_CH=16, DATA_W=12, data_in ch k = 12'h100+k, start pulse, out_ready=1 -> 16 consecutive beats 0x100..0x10F with ch_idx 0..15; frame_done pulses the cycle after beat 15; busy drops with it.
- Backpressure: out_ready toggles 1,0,0,1,... -> each beat is held stable while ready=0; no beat is dropped or duplicated; the order is still 0..15.
- Snapshot isolation: change all of data_in to 12'hFFF after beat 2 -> beats 3..15 still carry 0x103..0x10F.
- Continuous: cont=1, out_ready=1 -> frame 2 beat 0 directly follows frame 1 beat 15 with no gap, carrying data_in as sampled at that edge; frame_done pulses once per frame.
- Missed start: pulse start at beat 5 -> start_missed=1 and stays high through frame end; the next accepted start clears it; frame length stays 16.
- Reset mid-frame: rst_n low at beat 7 -> all outputs 0 asynchronously, no frame_done; after release plus start, a full frame restarts at ch_idx 0. Also run N_CH=5, DATA_W=8: ch_idx wraps after 4.

Source files
------------

// File: rtl/chan_scan_serializer.sv
// Snapshots N_CH parallel channel magnitudes on a start request and streams them out
// one channel per valid/ready handshake, tagged with the channel index.
module chan_scan_serializer #(
   parameter int N_CH   = 16,
   parameter int DATA_W = 12,
   parameter int IDX_W  = $clog2(N_CH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_CH*DATA_W-1:0]   data_in,
   input  logic                     start,
   input  logic                     cont,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        data_out,
   output logic [IDX_W-1:0]         ch_idx,
   output logic                     busy,
   output logic                     frame_done,
   output logic                     start_missed
);

   typedef enum logic {IDLE, SEND} state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

   state_t            state_reg;
   logic [DATA_W-1:0] chan_in  [N_CH];
   logic [DATA_W-1:0] snap_reg [N_CH];
   logic [IDX_W-1:0]  idx_next;
   logic              xfer;
   logic              last_beat;
   logic              recapture;

   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
         assign chan_in[gi] = data_in[gi*DATA_W +: DATA_W];
      end
   endgenerate

   // ch_idx doubles as the frame position; it never exceeds N_CH-1, so idx_next
   // is only used to address the snapshot when it is still in range.
   assign idx_next  = ch_idx + IDX_W'(1);
   assign xfer      = out_valid & out_ready;
   assign last_beat = (ch_idx == LAST_IDX);
   assign recapture = (state_reg == SEND) & xfer & last_beat & cont;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         out_valid    <= 1'b0;
         data_out     <= '0;
         ch_idx       <= '0;
         busy         <= 1'b0;
         frame_done   <= 1'b0;
         start_missed <= 1'b0;
         for (int i = 0; i < N_CH; i++) begin
            snap_reg[i] <= '0;
         end
      end else begin
         frame_done <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  for (int i = 0; i < N_CH; i++) begin
                     snap_reg[i] <= chan_in[i];
                  end
                  state_reg    <= SEND;
                  out_valid    <= 1'b1;
                  data_out     <= chan_in[0];
                  ch_idx       <= '0;
                  busy         <= 1'b1;
                  start_missed <= 1'b0;
               end
            end
            SEND: begin
               // A start coinciding with a continuous-mode wrap is absorbed by the new frame.
               if (start && !recapture) begin
                  start_missed <= 1'b1;
               end
               if (xfer) begin
                  if (!last_beat) begin
                     ch_idx   <= idx_next;
                     data_out <= snap_reg[idx_next];
                  end else begin
                     frame_done <= 1'b1;
                     if (cont) begin
                        for (int i = 0; i < N_CH; i++) begin
                           snap_reg[i] <= chan_in[i];
                        end
                        data_out <= chan_in[0];
                        ch_idx   <= '0;
                     end else begin
                        state_reg <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                     end
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_chan_scan_serializer.sv
// Bench for chan_scan_serializer: a queue-based frame model checked every cycle,
// plus directed scenarios with literal expectations on the collected beat stream.
module tb_chan_scan_serializer;

   localparam int N  = 16;
   localparam int W  = 12;
   localparam int NB = 5;
   localparam int WB = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N*W-1:0] data_in;
   logic           start, cont, out_ready;
   logic           out_valid, busy, frame_done, start_missed;
   logic [W-1:0]   data_out;
   logic [3:0]     ch_idx;

   logic [NB*WB-1:0] b_data_in;
   logic             b_start, b_cont, b_out_ready;
   logic             b_out_valid, b_busy, b_frame_done, b_start_missed;
   logic [WB-1:0]    b_data_out;
   logic [2:0]       b_ch_idx;

   chan_scan_serializer #(.N_CH(N), .DATA_W(W)) dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .start(start), .cont(cont),
      .out_ready(out_ready), .out_valid(out_valid), .data_out(data_out), .ch_idx(ch_idx),
      .busy(busy), .frame_done(frame_done), .start_missed(start_missed)
   );

   chan_scan_serializer #(.N_CH(NB), .DATA_W(WB)) dut_b (
      .clk(clk), .rst_n(rst_n), .data_in(b_data_in), .start(b_start), .cont(b_cont),
      .out_ready(b_out_ready), .out_valid(b_out_valid), .data_out(b_data_out), .ch_idx(b_ch_idx),
      .busy(b_busy), .frame_done(b_frame_done), .start_missed(b_start_missed)
   );

   int checks   = 0;
   int errors   = 0;
   int cyc      = 0;
   int done_cnt = 0;

   // Model: a frame is a queue of pending beat values; the head is what must be on the bus.
   logic [W-1:0] m_q[$];
   int           m_pos;
   bit           m_busy, m_done, m_missed;

   // Beat stream actually accepted from the DUT.
   logic [W-1:0] bq[$];
   int           bi[$];
   int           bs[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic set_data(input logic [W-1:0] base);
      for (int k = 0; k < N; k++) data_in[k*W +: W] = base + W'(k);
   endtask

   task automatic m_reset();
      m_q.delete();
      m_pos    = 0;
      m_busy   = 0;
      m_done   = 0;
      m_missed = 0;
   endtask

   task automatic m_load();
      m_q.delete();
      for (int k = 0; k < N; k++) m_q.push_back(data_in[k*W +: W]);
      m_pos = 0;
   endtask

   task automatic model_update();
      if (!rst_n) begin
         m_reset();
      end else begin
         m_done = 0;
         if (!m_busy) begin
            if (start) begin
               m_load();
               m_busy   = 1;
               m_missed = 0;
            end
         end else begin
            if (start && !(out_ready && m_q.size() == 1 && cont)) m_missed = 1;
            if (out_ready) begin
               void'(m_q.pop_front());
               m_pos++;
               if (m_q.size() == 0) begin
                  m_done = 1;
                  if (cont) m_load();
                  else      m_busy = 0;
               end
            end
         end
      end
   endtask

   task automatic compare();
      if (!rst_n) begin
         chk("rst_valid", int'(out_valid), 0);
         chk("rst_data",  int'(data_out), 0);
         chk("rst_idx",   int'(ch_idx), 0);
         chk("rst_busy",  int'(busy), 0);
         chk("rst_done",  int'(frame_done), 0);
         chk("rst_missed", int'(start_missed), 0);
      end else begin
         chk("valid",  int'(out_valid), int'(m_busy));
         chk("busy",   int'(busy), int'(m_busy));
         chk("done",   int'(frame_done), int'(m_done));
         chk("missed", int'(start_missed), int'(m_missed));
         if (m_busy) begin
            chk("data", int'(data_out), int'(m_q[0]));
            chk("idx",  int'(ch_idx), m_pos);
         end
      end
      if (frame_done) done_cnt++;
   endtask

   task automatic record();
      if (out_valid && out_ready) begin
         bq.push_back(data_out);
         bi.push_back(int'(ch_idx));
         bs.push_back(cyc);
         $display("beat cycle=%0d ch=%0d data=%03h", cyc, ch_idx, data_out);
      end
   endtask

   task automatic cycle();
      record();
      @(posedge clk);
      cyc++;
      model_update();
      @(negedge clk);
      compare();
   endtask

   task automatic clear_beats();
      bq.delete();
      bi.delete();
      bs.delete();
   endtask

   task automatic wait_done(input int d0, input int budget);
      int c;
      c = 0;
      while (done_cnt == d0 && c < budget) begin
         cycle();
         c++;
      end
      chk("frame_done_seen", int'(done_cnt != d0), 1);
   endtask

   task automatic check_frame(input int off, input logic [W-1:0] base);
      chk("beat_count", int'(bq.size() >= off + N), 1);
      if (bq.size() >= off + N) begin
         for (int k = 0; k < N; k++) begin
            chk("beat_data", int'(bq[off+k]), int'(base + W'(k)));
            chk("beat_idx",  bi[off+k], k);
         end
      end
   endtask

   initial begin
      int  d0;
      bit  pulsed;
      m_reset();
      data_in     = '0;
      start       = 0;
      cont        = 0;
      out_ready   = 0;
      b_data_in   = '0;
      b_start     = 0;
      b_cont      = 0;
      b_out_ready = 0;
      repeat (3) cycle();
      rst_n = 1;
      cycle();

      // Single frame, ready always high.
      set_data(12'h100);
      out_ready = 1;
      clear_beats();
      d0 = done_cnt;
      start = 1;
      cycle();
      start = 0;
      wait_done(d0, 100);
      check_frame(0, 12'h100);
      if (bs.size() >= N) chk("back_to_back_span", bs[N-1] - bs[0], N - 1);
      chk("bq_exact_16", bq.size(), 16);
      cycle();

      // Backpressure 1,0,0 with input change after beat 2.
      clear_beats();
      d0 = done_cnt;
      start = 1;
      cycle();
      start = 0;
      for (int c = 0; c < 200 && done_cnt == d0; c++) begin
         out_ready = (c % 3 == 0);
         if (bq.size() >= 3) data_in = '1;
         cycle();
      end
      chk("bp_done", int'(done_cnt != d0), 1);
      check_frame(0, 12'h100);
      chk("bp_no_dup", bq.size(), 16);
      out_ready = 1;
      set_data(12'h100);
      cycle();

      // Missed start at beat 5.
      clear_beats();
      d0 = done_cnt;
      pulsed = 0;
      start = 1;
      cycle();
      start = 0;
      for (int c = 0; c < 100 && done_cnt == d0; c++) begin
         start = (!pulsed && out_valid && ch_idx == 4'd5);
         if (start) pulsed = 1;
         cycle();
      end
      start = 0;
      chk("ms_sticky_at_done", int'(start_missed), 1);
      check_frame(0, 12'h100);
      chk("ms_frame_len", bq.size(), 16);
      cycle();
      chk("ms_sticky_idle", int'(start_missed), 1);
      d0 = done_cnt;
      start = 1;
      cycle();
      start = 0;
      chk("ms_cleared", int'(start_missed), 0);
      chk("ms_new_valid", int'(out_valid), 1);
      chk("ms_new_idx", int'(ch_idx), 0);
      wait_done(d0, 100);
      cycle();

      // Continuous mode: two frames, second carries data present at the wrap edge.
      clear_beats();
      d0 = done_cnt;
      cont = 1;
      start = 1;
      cycle();
      start = 0;
      for (int c = 0; c < 200 && done_cnt < d0 + 2; c++) begin
         if (done_cnt == d0 && ch_idx == 4'd10) set_data(12'h200);
         if (done_cnt == d0 + 1) cont = 0;
         cycle();
      end
      cont = 0;
      chk("cont_frames", done_cnt - d0, 2);
      chk("cont_beats", bq.size(), 32);
      check_frame(0, 12'h100);
      check_frame(16, 12'h200);
      if (bs.size() >= 17) chk("cont_no_gap", bs[16] - bs[15], 1);
      set_data(12'h100);
      cycle();

      // Reset mid-frame at beat 7, then a restart with start held high throughout.
      clear_beats();
      start = 1;
      cycle();
      start = 0;
      for (int c = 0; c < 50 && ch_idx != 4'd7; c++) cycle();
      chk("reached_beat7", int'(ch_idx), 7);
      d0 = done_cnt;
      rst_n = 0;
      m_reset();
      #1;
      chk("async_valid", int'(out_valid), 0);
      chk("async_data",  int'(data_out), 0);
      chk("async_idx",   int'(ch_idx), 0);
      chk("async_busy",  int'(busy), 0);
      cycle();
      cycle();
      chk("rst_no_done", done_cnt - d0, 0);
      rst_n = 1;
      cycle();
      clear_beats();
      d0 = done_cnt;
      start = 1;
      cycle();
      wait_done(d0, 100);
      check_frame(0, 12'h100);
      chk("held_start_missed", int'(start_missed), 1);
      cycle();
      chk("held_start_recap_valid", int'(out_valid), 1);
      chk("held_start_recap_idx", int'(ch_idx), 0);
      chk("held_start_recap_missed", int'(start_missed), 0);
      start = 0;
      wait_done(done_cnt, 100);
      cycle();

      // Non-power-of-two instance: N_CH=5, DATA_W=8.
      for (int k = 0; k < NB; k++) b_data_in[k*WB +: WB] = 8'h30 + WB'(k);
      b_out_ready = 1;
      b_start = 1;
      cycle();
      b_start = 0;
      for (int k = 0; k < NB; k++) begin
         chk("b_valid", int'(b_out_valid), 1);
         chk("b_idx",   int'(b_ch_idx), k);
         chk("b_data",  int'(b_data_out), 8'h30 + k);
         cycle();
      end
      chk("b_done",     int'(b_frame_done), 1);
      chk("b_idle",     int'(b_out_valid), 0);
      chk("b_busy_low", int'(b_busy), 0);
      b_start = 1;
      cycle();
      b_start = 0;
      chk("b_wrap_idx",  int'(b_ch_idx), 0);
      chk("b_wrap_data", int'(b_data_out), 8'h30);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
